// File: rtl/spi_pad_pkg.sv
// Shared types and lane-mapping helpers for the SPI master pad controller.
// The mode encoding matches the core's pad-mode request bus.
package spi_pad_pkg;

    localparam int MAX_LANES = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        STD      = 3'd1,
        DUAL_TX  = 3'd2,
        DUAL_RX  = 3'd3,
        QUAD_TX  = 3'd4,
        QUAD_RX  = 3'd5,
        OCTAL_TX = 3'd6,
        OCTAL_RX = 3'd7
    } spi_pad_mode_e;

    typedef enum logic {
        ACTIVE = 1'b0,
        DRAIN  = 1'b1
    } spi_pad_state_e;

    // Number of data lanes a mode occupies; STD counts as one lane because
    // it needs at least two physical pads, which every legal build has.
    function automatic int mode_lanes(input spi_pad_mode_e mode);
        case (mode)
            STD:                 return 1;
            DUAL_TX, DUAL_RX:    return 2;
            QUAD_TX, QUAD_RX:    return 4;
            OCTAL_TX, OCTAL_RX:  return 8;
            default:             return 0;
        endcase
    endfunction

    function automatic logic mode_is_tx(input spi_pad_mode_e mode);
        return (mode == STD) || (mode == DUAL_TX) || (mode == QUAD_TX) ||
               (mode == OCTAL_TX);
    endfunction

    function automatic logic mode_is_legal(input spi_pad_mode_e mode, input int num_lanes);
        return mode_lanes(mode) <= num_lanes;
    endfunction

    function automatic logic [MAX_LANES-1:0] lane_fill(input int k);
        logic [MAX_LANES-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (i < k) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Output-enable pattern for a mode; illegal modes collapse to all hi-Z.
    function automatic logic [MAX_LANES-1:0] oe_mask(input spi_pad_mode_e mode,
                                                     input int num_lanes);
        if (!mode_is_legal(mode, num_lanes) || !mode_is_tx(mode)) return '0;
        return lane_fill(mode_lanes(mode));
    endfunction

    // Lanes sensed as inputs. STD senses pad lane 1 (remapped to sdi[0] later).
    function automatic logic [MAX_LANES-1:0] in_mask(input spi_pad_mode_e mode,
                                                     input int num_lanes);
        logic [MAX_LANES-1:0] m;
        m = '0;
        if (mode_is_legal(mode, num_lanes)) begin
            if (mode == STD) begin
                m[1] = 1'b1;
            end else if (!mode_is_tx(mode)) begin
                m = lane_fill(mode_lanes(mode));
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/spi_pad_sample_dly.sv
// Per-lane input delay line with a tap mux; tap 0 is the live pad value.
// Out-of-range delay selects saturate at the deepest tap.
module spi_pad_sample_dly #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 3,
    parameter int DW    = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic [DW-1:0]    dly_i,
    output logic [WIDTH-1:0] dout_o
);

    logic [WIDTH-1:0] sr_q [DEPTH];
    logic [WIDTH-1:0] sr_d [DEPTH];
    logic [WIDTH-1:0] taps [DEPTH+1];
    logic [DW-1:0]    sel;

    always_comb begin
        sr_d[0] = din_i;
        for (int i = 1; i < DEPTH; i++) begin
            sr_d[i] = sr_q[i-1];
        end
    end

    // NOTE: the delay line is cleared on reset so no stale pad history leaks
    // into spi_sdi_o after reset; that is why this array is not a plain RAM.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                sr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                sr_q[i] <= sr_d[i];
            end
        end
    end

    always_comb begin
        taps[0] = din_i;
        for (int i = 1; i <= DEPTH; i++) begin
            taps[i] = sr_q[i-1];
        end
    end

    assign sel = (dly_i > DW'(DEPTH)) ? DW'(DEPTH) : dly_i;

    // NOTE: dout_o gets a default before the mux loop so no latch is inferred.
    always_comb begin
        dout_o = '0;
        for (int i = 0; i <= DEPTH; i++) begin
            if (sel == DW'(i)) dout_o = taps[i];
        end
    end

endmodule

// File: rtl/spi_master_pad_ctrl.sv
// Pad mux between the SPI master core and bidirectional pad cells, with a
// mode-change handshake that forces all data OEs low for TURNAROUND cycles.
module spi_master_pad_ctrl
    import spi_pad_pkg::*;
#(
    parameter int NUM_LANES      = 4,
    parameter int NUM_CS         = 1,
    parameter int TURNAROUND     = 2,
    parameter int MAX_SAMPLE_DLY = 3
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [2:0]                            mode_i,
    input  logic                                  mode_valid_i,
    output logic                                  mode_ready_o,
    output logic                                  mode_err_o,
    output logic                                  busy_o,
    input  logic [$clog2(MAX_SAMPLE_DLY+1)-1:0]   sample_dly_i,
    input  logic                                  spi_sck_i,
    input  logic [NUM_CS-1:0]                     spi_csn_i,
    input  logic [NUM_LANES-1:0]                  spi_sdo_i,
    output logic [NUM_LANES-1:0]                  spi_sdi_o,
    output logic                                  pad_sck_o,
    output logic                                  pad_sck_oe_o,
    output logic [NUM_CS-1:0]                     pad_csn_o,
    output logic [NUM_CS-1:0]                     pad_csn_oe_o,
    output logic [NUM_LANES-1:0]                  pad_dio_o,
    output logic [NUM_LANES-1:0]                  pad_dio_oe_o,
    input  logic [NUM_LANES-1:0]                  pad_dio_i
);

    localparam int CW = $clog2(TURNAROUND + 1);
    localparam int DW = $clog2(MAX_SAMPLE_DLY + 1);

    spi_pad_state_e         state_q, state_d;
    spi_pad_mode_e          cur_mode_q, cur_mode_d;
    spi_pad_mode_e          pend_mode_q, pend_mode_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [NUM_LANES-1:0]   oe_q, oe_d;
    logic [NUM_LANES-1:0]   in_mask_q, in_mask_d;
    logic                   std_q, std_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic                   err_q, err_d;

    spi_pad_mode_e          req_mode;
    logic                   accept;
    logic [NUM_LANES-1:0]   dly_data;
    logic [NUM_LANES-1:0]   sdi;

    assign req_mode = spi_pad_mode_e'(mode_i);
    assign accept   = mode_valid_i && ready_q;

    always_comb begin
        state_d     = state_q;
        cur_mode_d  = cur_mode_q;
        pend_mode_d = pend_mode_q;
        cnt_d       = cnt_q;
        oe_d        = oe_q;
        in_mask_d   = in_mask_q;
        std_d       = std_q;
        ready_d     = ready_q;
        busy_d      = busy_q;
        err_d       = 1'b0;

        case (state_q)
            ACTIVE: begin
                // Same-mode requests are acknowledged without disturbing the pads.
                if (accept && (req_mode != cur_mode_q)) begin
                    if (mode_is_legal(req_mode, NUM_LANES)) begin
                        pend_mode_d = req_mode;
                    end else begin
                        pend_mode_d = IDLE;
                        err_d       = 1'b1;
                    end
                    state_d   = DRAIN;
                    cnt_d     = CW'(TURNAROUND - 1);
                    oe_d      = '0;
                    in_mask_d = '0;
                    std_d     = 1'b0;
                    ready_d   = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            DRAIN: begin
                if (cnt_q == '0) begin
                    state_d    = ACTIVE;
                    cur_mode_d = pend_mode_q;
                    oe_d       = NUM_LANES'(oe_mask(pend_mode_q, NUM_LANES));
                    in_mask_d  = NUM_LANES'(in_mask(pend_mode_q, NUM_LANES));
                    std_d      = (pend_mode_q == STD);
                    ready_d    = 1'b1;
                    busy_d     = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ACTIVE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; blocking here
    // would make the update order of these flops depend on statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ACTIVE;
            cur_mode_q  <= IDLE;
            pend_mode_q <= IDLE;
            cnt_q       <= '0;
            oe_q        <= '0;
            in_mask_q   <= '0;
            std_q       <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_mode_q  <= cur_mode_d;
            pend_mode_q <= pend_mode_d;
            cnt_q       <= cnt_d;
            oe_q        <= oe_d;
            in_mask_q   <= in_mask_d;
            std_q       <= std_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    spi_pad_sample_dly #(
        .WIDTH (NUM_LANES),
        .DEPTH (MAX_SAMPLE_DLY),
        .DW    (DW)
    ) u_sample_dly (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .din_i  (pad_dio_i),
        .dly_i  (sample_dly_i),
        .dout_o (dly_data)
    );

    // STD receives on pad lane 1 but the core expects it on sdi[0].
    always_comb begin
        sdi = dly_data & in_mask_q;
        if (std_q) begin
            sdi    = '0;
            sdi[0] = dly_data[1] & in_mask_q[1];
        end
    end

    assign spi_sdi_o    = sdi;
    assign mode_ready_o = ready_q;
    assign busy_o       = busy_q;
    assign mode_err_o   = err_q;

    assign pad_sck_o    = spi_sck_i;
    assign pad_sck_oe_o = 1'b1;
    assign pad_csn_o    = spi_csn_i;
    assign pad_csn_oe_o = '1;
    assign pad_dio_oe_o = oe_q;
    assign pad_dio_o    = spi_sdo_i & oe_q;

endmodule

// File: tb/tb_spi_master_pad_ctrl.sv
// Directed bench for spi_master_pad_ctrl (4 lanes, turnaround 2, max delay 3):
// mode handshake, turnaround timing, sample delay, illegal mode, reset in drain.
module tb_spi_master_pad_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [2:0] mode_i;
    logic       mode_valid_i;
    logic       mode_ready_o;
    logic       mode_err_o;
    logic       busy_o;
    logic [1:0] sample_dly_i;
    logic       spi_sck_i;
    logic [0:0] spi_csn_i;
    logic [3:0] spi_sdo_i;
    logic [3:0] spi_sdi_o;
    logic       pad_sck_o;
    logic       pad_sck_oe_o;
    logic [0:0] pad_csn_o;
    logic [0:0] pad_csn_oe_o;
    logic [3:0] pad_dio_o;
    logic [3:0] pad_dio_oe_o;
    logic [3:0] pad_dio_i;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q [$];

    always #5 clk_i = ~clk_i;

    spi_master_pad_ctrl #(
        .NUM_LANES      (4),
        .NUM_CS         (1),
        .TURNAROUND     (2),
        .MAX_SAMPLE_DLY (3)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .mode_i       (mode_i),
        .mode_valid_i (mode_valid_i),
        .mode_ready_o (mode_ready_o),
        .mode_err_o   (mode_err_o),
        .busy_o       (busy_o),
        .sample_dly_i (sample_dly_i),
        .spi_sck_i    (spi_sck_i),
        .spi_csn_i    (spi_csn_i),
        .spi_sdo_i    (spi_sdo_i),
        .spi_sdi_o    (spi_sdi_o),
        .pad_sck_o    (pad_sck_o),
        .pad_sck_oe_o (pad_sck_oe_o),
        .pad_csn_o    (pad_csn_o),
        .pad_csn_oe_o (pad_csn_oe_o),
        .pad_dio_o    (pad_dio_o),
        .pad_dio_oe_o (pad_dio_oe_o),
        .pad_dio_i    (pad_dio_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Drive a request for exactly one edge, then release valid.
    task automatic request(input logic [2:0] mode);
        mode_i       = mode;
        mode_valid_i = 1'b1;
        tick();
        mode_valid_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i        = 1'b1;
        mode_i       = 3'd0;
        mode_valid_i = 1'b0;
        sample_dly_i = 2'd0;
        spi_sck_i    = 1'b0;
        spi_csn_i    = 1'b0;
        spi_sdo_i    = 4'hF;
        pad_dio_i    = 4'h0;
        tick();
        tick();

        // Reset state
        check("rst_oe",      32'(pad_dio_oe_o), 32'h0);
        check("rst_dio",     32'(pad_dio_o),    32'h0);
        check("rst_csn",     32'(pad_csn_o),    32'h0);
        check("rst_csn_oe",  32'(pad_csn_oe_o), 32'h1);
        check("rst_sck_oe",  32'(pad_sck_oe_o), 32'h1);
        check("rst_ready",   32'(mode_ready_o), 32'h1);
        check("rst_busy",    32'(busy_o),       32'h0);
        check("rst_err",     32'(mode_err_o),   32'h0);
        check("rst_sdi",     32'(spi_sdi_o),    32'h0);
        spi_sck_i = 1'b1;
        spi_csn_i = 1'b1;
        #1;
        check("sck_pass",    32'(pad_sck_o),    32'h1);
        check("csn_pass",    32'(pad_csn_o),    32'h1);
        rst_i = 1'b0;
        tick();

        // IDLE -> STD
        request(3'd1);
        check("std_d1_oe",   32'(pad_dio_oe_o), 32'h0);
        check("std_d1_busy", 32'(busy_o),       32'h1);
        check("std_d1_rdy",  32'(mode_ready_o), 32'h0);
        tick();
        check("std_d2_oe",   32'(pad_dio_oe_o), 32'h0);
        check("std_d2_busy", 32'(busy_o),       32'h1);
        tick();
        check("std_oe",      32'(pad_dio_oe_o), 32'h1);
        check("std_rdy",     32'(mode_ready_o), 32'h1);
        check("std_busy",    32'(busy_o),       32'h0);
        check("std_dio",     32'(pad_dio_o),    32'h1);
        pad_dio_i = 4'b0010;
        #1;
        check("std_sdi",     32'(spi_sdi_o),    32'h1);

        // STD -> QUAD_TX
        request(3'd4);
        tick();
        tick();
        check("qtx_oe",      32'(pad_dio_oe_o), 32'hF);
        spi_sdo_i = 4'b0110;
        #1;
        check("qtx_dio",     32'(pad_dio_o),    32'h6);

        // QUAD_TX -> QUAD_RX; a changed request held in DRAIN must be ignored
        mode_i       = 3'd5;
        mode_valid_i = 1'b1;
        #1;
        check("qrx_pre_oe",  32'(pad_dio_oe_o), 32'hF);
        tick();
        mode_i = 3'd4;
        check("qrx_d1_oe",   32'(pad_dio_oe_o), 32'h0);
        check("qrx_d1_busy", 32'(busy_o),       32'h1);
        check("qrx_d1_rdy",  32'(mode_ready_o), 32'h0);
        tick();
        check("qrx_d2_oe",   32'(pad_dio_oe_o), 32'h0);
        check("qrx_d2_busy", 32'(busy_o),       32'h1);
        mode_valid_i = 1'b0;
        tick();
        check("qrx_rdy",     32'(mode_ready_o), 32'h1);
        check("qrx_busy",    32'(busy_o),       32'h0);
        check("qrx_oe",      32'(pad_dio_oe_o), 32'h0);
        tick();
        tick();
        check("qrx_hold_oe", 32'(pad_dio_oe_o), 32'h0);
        check("qrx_hold_bs", 32'(busy_o),       32'h0);
        pad_dio_i = 4'b0101;
        #1;
        check("qrx_sdi",     32'(spi_sdi_o),    32'h5);

        // Sample delay 2: one-cycle pulse appears two cycles later
        pad_dio_i    = 4'h0;
        sample_dly_i = 2'd2;
        tick();
        tick();
        tick();
        pad_dio_i = 4'b1010;
        exp_q.push_back(4'h0);
        exp_q.push_back(4'h0);
        exp_q.push_back(4'hA);
        exp_q.push_back(4'h0);
        exp_q.push_back(4'h0);
        #1;
        check("dly2_c0",     32'(spi_sdi_o),    32'(exp_q.pop_front()));
        tick();
        pad_dio_i = 4'h0;
        #1;
        check("dly2_c1",     32'(spi_sdi_o),    32'(exp_q.pop_front()));
        for (int i = 2; i < 5; i++) begin
            tick();
            check($sformatf("dly2_c%0d", i), 32'(spi_sdi_o), 32'(exp_q.pop_front()));
        end
        sample_dly_i = 2'd0;

        // Illegal OCTAL_TX with 4 lanes -> IDLE plus one-cycle error pulse
        request(3'd6);
        check("ill_err1",    32'(mode_err_o),   32'h1);
        check("ill_busy",    32'(busy_o),       32'h1);
        tick();
        check("ill_err2",    32'(mode_err_o),   32'h0);
        tick();
        check("ill_rdy",     32'(mode_ready_o), 32'h1);
        check("ill_oe",      32'(pad_dio_oe_o), 32'h0);
        pad_dio_i = 4'hF;
        #1;
        check("ill_sdi",     32'(spi_sdi_o),    32'h0);

        // Reset during the first DRAIN cycle discards the pending QUAD_TX
        request(3'd4);
        check("rd_busy",     32'(busy_o),       32'h1);
        rst_i = 1'b1;
        tick();
        check("rd_rdy",      32'(mode_ready_o), 32'h1);
        check("rd_busy0",    32'(busy_o),       32'h0);
        check("rd_oe",       32'(pad_dio_oe_o), 32'h0);
        rst_i = 1'b0;
        tick();
        tick();
        tick();
        check("rd_late_oe",  32'(pad_dio_oe_o), 32'h0);
        check("rd_late_bs",  32'(busy_o),       32'h0);

        // IDLE -> DUAL_TX, then a repeated DUAL_TX request is a no-op
        spi_sdo_i = 4'hF;
        request(3'd2);
        tick();
        tick();
        check("dtx_oe",      32'(pad_dio_oe_o), 32'h3);
        check("dtx_dio",     32'(pad_dio_o),    32'h3);
        mode_i       = 3'd2;
        mode_valid_i = 1'b1;
        tick();
        check("same_rdy",    32'(mode_ready_o), 32'h1);
        check("same_busy",   32'(busy_o),       32'h0);
        check("same_oe",     32'(pad_dio_oe_o), 32'h3);
        mode_valid_i = 1'b0;
        tick();
        check("same_busy2",  32'(busy_o),       32'h0);
        check("same_oe2",    32'(pad_dio_oe_o), 32'h3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
